// File: rtl/mux_scan_sequencer_if.sv
// Control/status bus between the SPI register file and the mux scan sequencer.
interface mux_scan_sequencer_if #(
   parameter int unsigned N_CH    = 8,
   parameter int unsigned DWELL_W = 16,
   parameter int unsigned DEAD_W  = 4
);
   logic [N_CH-1:0]    cfg_mask;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [DEAD_W-1:0]  cfg_dead;
   logic               cfg_cont;
   logic               cfg_manual;
   logic [2:0]         cfg_manual_ch;
   logic               start;
   logic               stop;

   logic [N_CH-1:0]    dout_p;
   logic [N_CH-1:0]    dout_n;
   logic [2:0]         ch_idx;
   logic               busy;
   logic               ch_done;
   logic               scan_done;
   logic               cfg_err;

   modport master (
      output cfg_mask, cfg_dwell, cfg_dead, cfg_cont, cfg_manual, cfg_manual_ch, start, stop,
      input  dout_p, dout_n, ch_idx, busy, ch_done, scan_done, cfg_err
   );

   modport slave (
      input  cfg_mask, cfg_dwell, cfg_dead, cfg_cont, cfg_manual, cfg_manual_ch, start, stop,
      output dout_p, dout_n, ch_idx, busy, ch_done, scan_done, cfg_err
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Break-before-make gate sequencer for the 8:1 analog mux: scans enabled
// channels with programmable dwell/dead time, or holds one manual channel.
module mux_scan_sequencer #(
   parameter int unsigned N_CH    = 8,
   parameter int unsigned DWELL_W = 16,
   parameter int unsigned DEAD_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_scan_sequencer_if.slave   bus
);
   localparam int unsigned CH_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_DEAD, S_DWELL, S_HOLD} state_e;

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
   logic [N_CH-1:0]    mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DEAD_W-1:0]  dead_q, dead_d;
   logic               cont_q, cont_d;
   logic               manual_q, manual_d;
   logic [N_CH-1:0]    dout_p_q, dout_p_d;
   logic [N_CH-1:0]    dout_n_q, dout_n_d;
   logic               busy_q, busy_d;
   logic               ch_done_q, ch_done_d;
   logic               scan_done_q, scan_done_d;
   logic               cfg_err_q, cfg_err_d;
   logic [CH_W:0]      nxt_cur, nxt_new;

   // Lowest enabled channel in a mask.
   function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
      lowest_ch = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (m[i]) lowest_ch = CH_W'(i);
      end
   endfunction

   // Next enabled channel above cur, wrapping; MSB flags that the search wrapped.
   function automatic logic [CH_W:0] next_ch(input logic [N_CH-1:0] m, input logic [CH_W-1:0] cur);
      logic [CH_W-1:0] idx;
      logic            found;
      next_ch = {1'b0, cur};
      found   = 1'b0;
      for (int i = 1; i <= int'(N_CH); i++) begin
         idx = cur + CH_W'(i);
         if (!found && m[idx]) begin
            found   = 1'b1;
            next_ch = {idx <= cur, idx};
         end
      end
   endfunction

   // Dead counter preload: counts D-1 down to 0, with a dead setting of 0 acting as 1.
   function automatic logic [DEAD_W-1:0] dead_load(input logic [DEAD_W-1:0] d);
      dead_load = (d == '0) ? '0 : d - DEAD_W'(1);
   endfunction

   // State, counters, latched config and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         dwell_cnt_q <= '0;
         dead_cnt_q  <= '0;
         mask_q      <= '0;
         dwell_q     <= '0;
         dead_q      <= '0;
         cont_q      <= 1'b0;
         manual_q    <= 1'b0;
         dout_p_q    <= '0;
         dout_n_q    <= '1;
         busy_q      <= 1'b0;
         ch_done_q   <= 1'b0;
         scan_done_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         dwell_cnt_q <= dwell_cnt_d;
         dead_cnt_q  <= dead_cnt_d;
         mask_q      <= mask_d;
         dwell_q     <= dwell_d;
         dead_q      <= dead_d;
         cont_q      <= cont_d;
         manual_q    <= manual_d;
         dout_p_q    <= dout_p_d;
         dout_n_q    <= dout_n_d;
         busy_q      <= busy_d;
         ch_done_q   <= ch_done_d;
         scan_done_q <= scan_done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      dwell_cnt_d = dwell_cnt_q;
      dead_cnt_d  = dead_cnt_q;
      mask_d      = mask_q;
      dwell_d     = dwell_q;
      dead_d      = dead_q;
      cont_d      = cont_q;
      manual_d    = manual_q;
      cfg_err_d   = 1'b0;
      nxt_cur     = next_ch(mask_q, ch_q);

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               if (bus.cfg_manual || (bus.cfg_mask != '0)) begin
                  mask_d     = bus.cfg_mask;
                  dwell_d    = bus.cfg_dwell;
                  dead_d     = bus.cfg_dead;
                  cont_d     = bus.cfg_cont;
                  manual_d   = bus.cfg_manual;
                  ch_d       = bus.cfg_manual ? bus.cfg_manual_ch : lowest_ch(bus.cfg_mask);
                  dead_cnt_d = dead_load(bus.cfg_dead);
                  state_d    = S_DEAD;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_DEAD: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else if (dead_cnt_q == '0) begin
               state_d     = manual_q ? S_HOLD : S_DWELL;
               dwell_cnt_d = dwell_q;
            end else begin
               dead_cnt_d = dead_cnt_q - DEAD_W'(1);
            end
         end
         S_DWELL: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else if (dwell_cnt_q == '0) begin
               if (nxt_cur[CH_W] && !cont_q) begin
                  state_d = S_IDLE;
               end else begin
                  ch_d       = nxt_cur[CH_W-1:0];
                  dead_cnt_d = dead_load(dead_q);
                  state_d    = S_DEAD;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end
         end
         S_HOLD: begin
            if (bus.stop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs describe the cycle being entered.
      nxt_new     = next_ch(mask_d, ch_d);
      ch_done_d   = (state_d == S_DWELL) && (dwell_cnt_d == '0);
      scan_done_d = ch_done_d && nxt_new[CH_W];
      busy_d      = (state_d != S_IDLE);
      dout_p_d    = ((state_d == S_DWELL) || (state_d == S_HOLD)) ? (N_CH'(1) << ch_d) : '0;
      dout_n_d    = ~dout_p_d;
   end

   // A stop landing on the final dwell cycle suppresses that cycle's completion pulses.
   assign bus.dout_p    = dout_p_q;
   assign bus.dout_n    = dout_n_q;
   assign bus.ch_idx    = ch_q;
   assign bus.busy      = busy_q;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.ch_done   = ch_done_q & ~bus.stop;
   assign bus.scan_done = scan_done_q & ~bus.stop;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: a timeline model expands each
// configuration into expected per-cycle output frames; a monitor compares.
module tb_mux_scan_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_scan_sequencer_if bus_if ();
   mux_scan_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

   typedef struct packed {
      logic [7:0] dout_p;
      logic [2:0] ch;
      logic       busy;
      logic       ch_done;
      logic       scan_done;
      logic       cfg_err;
   } frame_t;

   frame_t     sb[$];
   frame_t     tl[$];
   logic [2:0] last_ch;
   logic [7:0] prev_p;
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic chk(input bit ok, input string msg);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s", msg);
   endtask

   function automatic frame_t idle_f(input logic [2:0] ch);
      idle_f    = '0;
      idle_f.ch = ch;
   endfunction

   function automatic frame_t off_f(input logic [2:0] ch);
      off_f      = '0;
      off_f.ch   = ch;
      off_f.busy = 1'b1;
   endfunction

   function automatic frame_t on_f(input logic [2:0] ch);
      on_f        = off_f(ch);
      on_f.dout_p = 8'(1) << ch;
   endfunction

   // Expected timeline: frame 0 is the start cycle; later frames follow the scan rules.
   task automatic build(input logic [7:0] mask, input int dwell, input int dead, input bit cont,
                        input bit manual, input logic [2:0] mch, input int ncyc);
      int         d;
      int         chans[$];
      bit         done;
      logic [2:0] pad_ch;
      frame_t     f;
      d      = (dead == 0) ? 1 : dead;
      pad_ch = last_ch;
      tl.delete();
      tl.push_back(idle_f(last_ch));
      if (manual) begin
         repeat (d) tl.push_back(off_f(mch));
         while (tl.size() < ncyc) tl.push_back(on_f(mch));
      end else if (mask == 8'h00) begin
         f         = idle_f(last_ch);
         f.cfg_err = 1'b1;
         tl.push_back(f);
      end else begin
         for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
         pad_ch = 3'(chans[chans.size() - 1]);
         done   = 1'b0;
         while (!done && tl.size() < ncyc) begin
            for (int k = 0; k < chans.size() && tl.size() < ncyc; k++) begin
               repeat (d) tl.push_back(off_f(3'(chans[k])));
               for (int j = 0; j <= dwell && tl.size() < ncyc; j++) begin
                  f = on_f(3'(chans[k]));
                  if (j == dwell) begin
                     f.ch_done   = 1'b1;
                     f.scan_done = (k == chans.size() - 1);
                  end
                  tl.push_back(f);
               end
            end
            if (!cont) done = 1'b1;
         end
      end
      while (tl.size() < ncyc) tl.push_back(idle_f(pad_ch));
   endtask

   // Run one configuration; optional stop, spurious starts and config churn.
   task automatic run(input logic [7:0] mask, input int dwell, input int dead, input bit cont,
                      input bit manual, input logic [2:0] mch, input int ncyc, input int stop_at,
                      input bit inject, input bit mutate);
      build(mask, dwell, dead, cont, manual, mch, ncyc);
      if (stop_at >= 0 && stop_at < ncyc) begin
         tl[stop_at].ch_done   = 1'b0;
         tl[stop_at].scan_done = 1'b0;
         for (int c = stop_at + 1; c < ncyc; c++) tl[c] = idle_f(tl[stop_at].ch);
      end
      bus_if.cfg_mask      = mask;
      bus_if.cfg_dwell     = 16'(dwell);
      bus_if.cfg_dead      = 4'(dead);
      bus_if.cfg_cont      = cont;
      bus_if.cfg_manual    = manual;
      bus_if.cfg_manual_ch = mch;
      for (int c = 0; c < ncyc; c++) begin
         bus_if.start = (c == 0) || (inject && tl[c].busy && ($urandom_range(0, 5) == 0));
         bus_if.stop  = (c == stop_at);
         if (mutate && c > 0) begin
            bus_if.cfg_mask      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bus_if.cfg_dwell     = 16'($urandom);
            bus_if.cfg_dead      = 4'($urandom);
            bus_if.cfg_cont      = 1'($urandom);
            bus_if.cfg_manual    = 1'($urandom);
            bus_if.cfg_manual_ch = 3'($urandom);
         end
         sb.push_back(tl[c]);
         @(posedge clk);
         #1;
      end
      bus_if.start = 1'b0;
      bus_if.stop  = 1'b0;
      last_ch      = tl[ncyc - 1].ch;
   endtask

   task automatic check_reset_values(input string name);
      frame_t act;
      act = {bus_if.dout_p, bus_if.ch_idx, bus_if.busy, bus_if.ch_done, bus_if.scan_done, bus_if.cfg_err};
      chk((act == frame_t'(0)) && (bus_if.dout_n == 8'hFF),
          $sformatf("%s got p=%h n=%h ch=%0d busy=%b cd=%b sd=%b err=%b want p=00 n=ff rest 0",
                    name, act.dout_p, bus_if.dout_n, act.ch, act.busy, act.ch_done, act.scan_done, act.cfg_err));
   endtask

   // Monitor: output invariants plus scoreboard comparison once per cycle.
   always @(negedge clk) begin
      frame_t act;
      frame_t exp;
      if (!rst_n) begin
         prev_p = 8'h00;
      end else begin
         chk($onehot0(bus_if.dout_p), $sformatf("onehot dout_p=%h want at most one bit", bus_if.dout_p));
         chk(bus_if.dout_n == ~bus_if.dout_p,
             $sformatf("complement dout_n=%h want %h", bus_if.dout_n, ~bus_if.dout_p));
         if (prev_p != 8'h00 && bus_if.dout_p != 8'h00)
            chk(prev_p == bus_if.dout_p,
                $sformatf("overlap dout_p=%h after %h want same channel or gap", bus_if.dout_p, prev_p));
         prev_p = bus_if.dout_p;
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            act = {bus_if.dout_p, bus_if.ch_idx, bus_if.busy, bus_if.ch_done, bus_if.scan_done, bus_if.cfg_err};
            chk(act === exp,
                $sformatf("frame @%0t got p=%h ch=%0d busy=%b cd=%b sd=%b err=%b want p=%h ch=%0d busy=%b cd=%b sd=%b err=%b",
                          $time, act.dout_p, act.ch, act.busy, act.ch_done, act.scan_done, act.cfg_err,
                          exp.dout_p, exp.ch, exp.busy, exp.ch_done, exp.scan_done, exp.cfg_err));
         end
      end
   end

   initial begin
      logic [7:0] m;
      bit         cont;
      bit         man;
      int         sa;
      rst_n                = 1'b0;
      prev_p               = 8'h00;
      last_ch              = 3'd0;
      bus_if.cfg_mask      = 8'h00;
      bus_if.cfg_dwell     = 16'h0;
      bus_if.cfg_dead      = 4'h0;
      bus_if.cfg_cont      = 1'b0;
      bus_if.cfg_manual    = 1'b0;
      bus_if.cfg_manual_ch = 3'd0;
      bus_if.start         = 1'b0;
      bus_if.stop          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset_state");
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(8'h25, 3, 2, 1'b0, 1'b0, 3'd0, 24, -1, 1'b0, 1'b0);       // single scan 0,2,5
      run(8'h80, 1, 0, 1'b1, 1'b0, 3'd0, 40, 35, 1'b0, 1'b0);       // continuous, one channel
      run(8'h00, 0, 3, 1'b0, 1'b1, 3'd6, 1008, 1003, 1'b0, 1'b0);   // manual hold ch6
      run(8'h00, 2, 1, 1'b0, 1'b0, 3'd0, 5, -1, 1'b0, 1'b0);        // empty mask rejected
      run(8'h5A, 2, 1, 1'b0, 1'b0, 3'd0, 40, -1, 1'b1, 1'b1);       // starts while busy ignored
      run(8'h0F, 2, 1, 1'b1, 1'b0, 3'd0, 6, 0, 1'b0, 1'b0);         // start+stop in idle
      run(8'h03, 2, 1, 1'b1, 1'b0, 3'd0, 12, 8, 1'b0, 1'b1);        // stop on final dwell cycle
      run(8'h10, 65535, 15, 1'b0, 1'b0, 3'd0, 60, 40, 1'b0, 1'b0);  // full-scale counters
      run(8'h81, 0, 15, 1'b0, 1'b0, 3'd0, 40, -1, 1'b0, 1'b0);      // zero dwell, max dead

      for (int it = 0; it < 25; it++) begin
         m    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         man  = ($urandom_range(0, 5) == 0);
         cont = 1'($urandom);
         if (cont || man) sa = $urandom_range(1, 100);
         else sa = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 100);
         run(m, $urandom_range(0, 5), $urandom_range(0, 3), cont, man, 3'($urandom), 120, sa, 1'b1, 1'b1);
      end

      // Async reset mid-dwell: outputs must clear without a clock edge.
      run(8'hFF, 10, 1, 1'b1, 1'b0, 3'd0, 6, -1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("async_reset_mid_dwell");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      last_ch = 3'd0;
      run(8'h24, 1, 1, 1'b0, 1'b0, 3'd0, 12, -1, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      chk(sb.size() == 0, $sformatf("scoreboard_drained left=%0d want 0", sb.size()));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
